// File: rtl/rabbit_keystream_xor.sv
// Rabbit keystream extraction and XOR onto a 32-bit valid/ready word stream.
// Optional RABBIT_KS_PREFETCH_EN adds a spare keystream buffer for gap-free blocks.
module rabbit_keystream_xor (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        step_req,
    input  logic        state_valid,
    input  logic [31:0] X0,
    input  logic [31:0] X1,
    input  logic [31:0] X2,
    input  logic [31:0] X3,
    input  logic [31:0] X4,
    input  logic [31:0] X5,
    input  logic [31:0] X6,
    input  logic [31:0] X7,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic [31:0] blk_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        READY = 2'd2
    } state_t;

    state_t       state;
    logic [1:0]   idx;
    logic [127:0] cur_buf;
    logic [127:0] ks_new;
    logic [31:0]  ks_word;
    logic         capture;
    logic         accept;
    logic         last_accept;

`ifdef RABBIT_KS_PREFETCH_EN
    logic [127:0] spare_buf;
    logic         spare_valid;
`endif

    always_comb begin
        ks_new = {X6[31:16] ^ X1[15:0],  X6[15:0] ^ X3[31:16],
                  X4[31:16] ^ X7[15:0],  X4[15:0] ^ X1[31:16],
                  X2[31:16] ^ X5[15:0],  X2[15:0] ^ X7[31:16],
                  X0[31:16] ^ X3[15:0],  X0[15:0] ^ X5[31:16]};
    end

    always_comb begin
        ks_word = cur_buf[31:0];
        case (idx)
            2'd0: ks_word = cur_buf[31:0];
            2'd1: ks_word = cur_buf[63:32];
            2'd2: ks_word = cur_buf[95:64];
            2'd3: ks_word = cur_buf[127:96];
            default: ks_word = cur_buf[31:0];
        endcase
    end

    // start wins over everything in its cycle: no accept, no capture.
    always_comb begin
        in_ready    = (state == READY) && !start && (!out_valid || out_ready);
        accept      = in_valid && in_ready;
        last_accept = accept && (idx == 2'd3);
        capture     = state_valid && step_req && !start;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ ks_word;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef RABBIT_KS_PREFETCH_EN
    // step_req tracks "spare empty and not IDLE"; capture fills cur in FETCH, spare otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            step_req    <= 1'b0;
            idx         <= '0;
            blk_count   <= '0;
            cur_buf     <= '0;
            spare_buf   <= '0;
            spare_valid <= 1'b0;
        end else if (start) begin
            state       <= FETCH;
            step_req    <= 1'b1;
            idx         <= '0;
            blk_count   <= '0;
            cur_buf     <= '0;
            spare_buf   <= '0;
            spare_valid <= 1'b0;
        end else begin
            case (state)
                FETCH: begin
                    if (capture) begin
                        cur_buf   <= ks_new;
                        idx       <= '0;
                        blk_count <= blk_count + 32'd1;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (accept)
                        idx <= idx + 2'd1;
                    if (last_accept) begin
                        if (spare_valid) begin
                            cur_buf     <= spare_buf;
                            spare_valid <= 1'b0;
                            step_req    <= 1'b1;
                        end else if (capture) begin
                            cur_buf   <= ks_new;
                            blk_count <= blk_count + 32'd1;
                        end else begin
                            state    <= FETCH;
                            step_req <= 1'b1;
                        end
                    end else if (capture) begin
                        spare_buf   <= ks_new;
                        spare_valid <= 1'b1;
                        step_req    <= 1'b0;
                        blk_count   <= blk_count + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            step_req  <= 1'b0;
            idx       <= '0;
            blk_count <= '0;
            cur_buf   <= '0;
        end else if (start) begin
            state     <= FETCH;
            step_req  <= 1'b1;
            idx       <= '0;
            blk_count <= '0;
            cur_buf   <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (capture) begin
                        cur_buf   <= ks_new;
                        idx       <= '0;
                        blk_count <= blk_count + 32'd1;
                        step_req  <= 1'b0;
                        state     <= READY;
                    end
                end
                READY: begin
                    if (accept)
                        idx <= idx + 2'd1;
                    if (last_accept) begin
                        state    <= FETCH;
                        step_req <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_rabbit_keystream_xor.sv
// Directed bench for rabbit_keystream_xor: expected words go to a queue, a monitor checks outputs.
module tb_rabbit_keystream_xor;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        step_req;
    logic        state_valid = 1'b0;
    logic [31:0] X0 = '0, X1 = '0, X2 = '0, X3 = '0;
    logic [31:0] X4 = '0, X5 = '0, X6 = '0, X7 = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_data;
    logic [31:0] blk_count;

    logic [31:0] exp_q[$];
    int n_cmp  = 0;
    int n_fail = 0;
    logic auto_en = 1'b0;

    rabbit_keystream_xor dut (
        .clk(clk), .rst(rst), .start(start), .step_req(step_req),
        .state_valid(state_valid),
        .X0(X0), .X1(X1), .X2(X2), .X3(X3), .X4(X4), .X5(X5), .X6(X6), .X7(X7),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .blk_count(blk_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_x(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
        X0 = a0; X1 = a1; X2 = a2; X3 = a3; X4 = a4; X5 = a5; X6 = a6; X7 = a7;
    endtask

    task automatic respond();
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (step_req) seen = 1;
            else tick();
        end
        chk("step_req_wait", {31'd0, seen}, 32'd1);
        state_valid = 1'b1;
        tick();
        state_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] d, input logic [31:0] e);
        bit done = 0;
        logic got;
        in_valid = 1'b1;
        in_data  = d;
        for (int i = 0; i < 50 && !done; i++) begin
            #3;
            got = in_ready;
            tick();
            if (got) begin
                exp_q.push_back(e);
                done = 1;
            end
        end
        in_valid = 1'b0;
        chk("send_timeout", {31'd0, done}, 32'd1);
    endtask

    // Monitor: every handshaked output word must match the head of the queue.
    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %h expected none", out_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_data", out_data, e);
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (auto_en) state_valid = step_req && !state_valid;
        end
    end

    initial begin
        #12;
        chk("rst_step_req", {31'd0, step_req}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_out_data", out_data, 32'd0);
        chk("rst_blk_count", blk_count, 32'd0);
        rst = 1'b0;
        tick();

        // state_valid while IDLE must be ignored
        set_x(32'h12345678, 0, 0, 0, 0, 0, 0, 0);
        state_valid = 1'b1;
        in_valid    = 1'b1;
        #3;
        chk("idle_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        state_valid = 1'b0;
        in_valid    = 1'b0;
        chk("idle_blk_count", blk_count, 32'd0);
        chk("idle_step_req", {31'd0, step_req}, 32'd0);

        // block 1: X0 only
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_step_req", {31'd0, step_req}, 32'd1);
        respond();
        chk("blk1_count", blk_count, 32'd1);
`ifdef RABBIT_KS_PREFETCH_EN
        chk("cap_step_req", {31'd0, step_req}, 32'd1);
`else
        chk("cap_step_req", {31'd0, step_req}, 32'd0);
`endif
        send_word(32'h0, 32'h12345678);
        send_word(32'h0, 32'h0);
        send_word(32'h0, 32'h0);
        send_word(32'h0, 32'h0);
        chk("blk_end_step_req", {31'd0, step_req}, 32'd1);

        // block 2: X5 only, all-ones data
        set_x(0, 0, 0, 0, 0, 32'hABCD0000, 0, 0);
        respond();
        chk("blk2_count", blk_count, 32'd2);
        send_word(32'hFFFFFFFF, 32'hFFFF5432);
        send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
        send_word(32'hFFFFFFFF, 32'hFFFFFFFF);
        send_word(32'hFFFFFFFF, 32'hFFFFFFFF);

        // block 3: every extraction term distinct, backpressure after word 1
        set_x(32'h00010100, 32'h00020200, 32'h00040400, 32'h00080800,
              32'h00101000, 32'h00202000, 32'h00404000, 32'h00808000);
        respond();
        chk("blk3_count", blk_count, 32'd3);
        send_word(32'h0, 32'h08010120);
        send_word(32'h0, 32'h20040480);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 32'h0;
        for (int i = 0; i < 5; i++) begin
            #3;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_out_data", out_data, 32'h20040480);
            tick();
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        send_word(32'h0, 32'h80101002);
        send_word(32'h11111111, 32'h13515119);
        chk("blk3_end_count", blk_count, 32'd3);

        // block 4, then start at idx==2
        set_x(32'hCAFEBABE, 0, 0, 0, 0, 0, 0, 0);
        respond();
        send_word(32'h0, 32'hCAFEBABE);
        send_word(32'h0, 32'h0);
        set_x(32'h0F0F0F0F, 0, 0, 0, 0, 0, 0, 0);
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 32'h55555555;
        #3;
        chk("start_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        start    = 1'b0;
        in_valid = 1'b0;
        chk("restart_blk_count", blk_count, 32'd0);
        respond();
        chk("restart_blk1", blk_count, 32'd1);
        send_word(32'h55555555, 32'h5A5A5A5A);

`ifdef RABBIT_KS_PREFETCH_EN
        begin
            int acc = 0;
            int gaps = 0;
            logic got;
            set_x(32'h12345678, 0, 0, 0, 0, 0, 0, 0);
            start = 1'b1;
            tick();
            start   = 1'b0;
            auto_en = 1'b1;
            in_valid = 1'b1;
            in_data  = 32'hA0000000;
            for (int c = 0; c < 200 && acc < 12; c++) begin
                #3;
                got = in_ready;
                tick();
                if (got) begin
                    exp_q.push_back(in_data ^ ((acc % 4 == 0) ? 32'h12345678 : 32'h0));
                    acc++;
                    in_data = 32'hA0000000 | acc;
                end else if (acc > 0) begin
                    gaps++;
                end
            end
            in_valid = 1'b0;
            chk("pf_blk_range", {31'd0, (blk_count == 32'd3 || blk_count == 32'd4)}, 32'd1);
            auto_en     = 1'b0;
            state_valid = 1'b0;
            chk("pf_accepted", acc, 32'd12);
            chk("pf_gaps", gaps, 32'd0);
        end
`endif

        for (int i = 0; i < 100 && exp_q.size() != 0; i++) tick();
        chk("drain", exp_q.size(), 32'd0);

        // asynchronous reset mid-block
        set_x(32'h1, 0, 0, 0, 0, 0, 0, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        respond();
        chk("pre_rst_blk", blk_count, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_step_req", {31'd0, step_req}, 32'd0);
        chk("arst_blk_count", blk_count, 32'd0);
        chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
        chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
        tick();
        rst = 1'b0;
        tick();
        chk("post_rst_in_ready", {31'd0, in_ready}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
